// File: rtl/id_hazard_scoreboard_pkg.sv
// rtl/id_hazard_scoreboard_pkg.sv - shared codes for the ID hazard/forwarding scoreboard
package id_hazard_scoreboard_pkg;

    typedef enum logic {
        WCLASS_ALU  = 1'b0,
        WCLASS_LOAD = 1'b1
    } wclass_e;

    localparam logic [1:0] FWD_SEL_REGFILE = 2'd0;
    localparam logic [1:0] FWD_SEL_LAST    = 2'd1;
    localparam logic [1:0] FWD_SEL_LAST2   = 2'd2;
    localparam logic [1:0] FWD_SEL_LAST3   = 2'd3;

    // Map a producer age onto the forward-select code of the stage holding it
    function automatic logic [1:0] fwd_from_age(input int age);
        case (age)
            1:       return FWD_SEL_LAST;
            2:       return FWD_SEL_LAST2;
            3:       return FWD_SEL_LAST3;
            default: return FWD_SEL_REGFILE;
        endcase
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_entry.sv
// rtl/id_hazard_scoreboard_entry.sv - one register's pending-write tracker (busy, age, class)
module hazard_sb_entry
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int AGE_W      = 2,
    parameter int PIPE_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             set,
    input  wclass_e          set_class,
    output logic             busy,
    output logic [AGE_W-1:0] age,
    output wclass_e          wclass
);

    // Flush beats freeze; a new producer overwrites the old one; otherwise age until retired
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy   <= 1'b0;
            age    <= '0;
            wclass <= WCLASS_ALU;
        end else if (flush) begin
            busy   <= 1'b0;
            age    <= '0;
            wclass <= WCLASS_ALU;
        end else if (!freeze) begin
            if (set) begin
                busy   <= 1'b1;
                age    <= AGE_W'(1);
                wclass <= set_class;
            end else if (busy) begin
                if (age == AGE_W'(PIPE_DEPTH)) begin
                    busy <= 1'b0;
                    age  <= '0;
                end else begin
                    age <= age + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - ID-stage stall and forward-select scoreboard
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = 4,
    parameter int NUM_SRC    = 2,
    parameter int PIPE_DEPTH = 3,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hsi_freeze,
    input  logic                      hsi_flush,
    input  logic                      hsi_issue_valid,
    input  logic [REG_AW-1:0]         hsi_wreg,
    input  logic                      hsi_wclass,
    input  logic [NUM_SRC*REG_AW-1:0] hsi_src_addr,
    output logic                      hso_stall,
    output logic [NUM_SRC*2-1:0]      hso_fwd_sel,
    output logic [2**REG_AW-1:0]      hso_busy_mask
);

    localparam int NUM_REG = 2**REG_AW;
    localparam int AGE_W   = $clog2(PIPE_DEPTH + 1);
    localparam logic [REG_AW-1:0] REG_INVALID = '1;

    logic [NUM_REG-1:0] busy_vec;
    logic [AGE_W-1:0]   age_arr   [NUM_REG];
    wclass_e            class_arr [NUM_REG];
    logic [REG_AW-1:0]  src_addr  [NUM_SRC];
    logic               issue_eff;

    assign issue_eff = hsi_issue_valid & ~hso_stall & ~hsi_freeze & ~hsi_flush
                     & (hsi_wreg != REG_INVALID);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REG - 1; gi++) begin : g_entry
            hazard_sb_entry #(
                .AGE_W      (AGE_W),
                .PIPE_DEPTH (PIPE_DEPTH)
            ) u_entry (
                .clk       (clk),
                .rst       (rst),
                .freeze    (hsi_freeze),
                .flush     (hsi_flush),
                .set       (issue_eff && (hsi_wreg == REG_AW'(gi))),
                .set_class (wclass_e'(hsi_wclass)),
                .busy      (busy_vec[gi]),
                .age       (age_arr[gi]),
                .wclass    (class_arr[gi])
            );
        end
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_addr[gi] = hsi_src_addr[gi*REG_AW +: REG_AW];
        end
    endgenerate

    // The invalid register is never tracked, so its slot reads as permanently idle
    assign busy_vec[NUM_REG-1]  = 1'b0;
    assign age_arr[NUM_REG-1]   = '0;
    assign class_arr[NUM_REG-1] = WCLASS_ALU;

    assign hso_busy_mask = busy_vec;

    // Per-source lookup against the registered table: forward when ready, stall otherwise
    always_comb begin
        hso_stall   = 1'b0;
        hso_fwd_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if ((src_addr[s] != REG_INVALID) && busy_vec[src_addr[s]]) begin
                if (int'(age_arr[src_addr[s]]) >=
                    ((class_arr[src_addr[s]] == WCLASS_LOAD) ? LOAD_READY : ALU_READY)) begin
                    hso_fwd_sel[s*2 +: 2] = fwd_from_age(int'(age_arr[src_addr[s]]));
                end else begin
                    hso_stall = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - scoreboard bench for id_hazard_scoreboard
module tb_id_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsi_freeze;
    logic        hsi_flush;
    logic        hsi_issue_valid;
    logic [3:0]  hsi_wreg;
    logic        hsi_wclass;
    logic [7:0]  hsi_src_addr;
    logic        hso_stall;
    logic [3:0]  hso_fwd_sel;
    logic [15:0] hso_busy_mask;

    typedef struct {
        string       name;
        logic        stall;
        logic [1:0]  f0;
        logic [1:0]  f1;
        logic [15:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    id_hazard_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .hsi_freeze      (hsi_freeze),
        .hsi_flush       (hsi_flush),
        .hsi_issue_valid (hsi_issue_valid),
        .hsi_wreg        (hsi_wreg),
        .hsi_wclass      (hsi_wclass),
        .hsi_src_addr    (hsi_src_addr),
        .hso_stall       (hso_stall),
        .hso_fwd_sel     (hso_fwd_sel),
        .hso_busy_mask   (hso_busy_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string what, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s.%s actual=%h required=%h", nm, what, act, exp);
    endtask

    // Monitor: compare DUT outputs against the queued expectation once per cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "stall", 16'(hso_stall), 16'(e.stall));
                chk(e.name, "fwd0", 16'(hso_fwd_sel[1:0]), 16'(e.f0));
                chk(e.name, "fwd1", 16'(hso_fwd_sel[3:2]), 16'(e.f1));
                chk(e.name, "mask", hso_busy_mask, e.mask);
            end
        end
    end

    task automatic step(input string nm, input logic rs, input logic iv, input logic [3:0] wr,
                        input logic wc, input logic [3:0] s0, input logic [3:0] s1,
                        input logic frz, input logic fl, input logic es,
                        input logic [1:0] e0, input logic [1:0] e1, input logic [15:0] em);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = rs;
        hsi_issue_valid = iv;
        hsi_wreg        = wr;
        hsi_wclass      = wc;
        hsi_src_addr    = {s1, s0};
        hsi_freeze      = frz;
        hsi_flush       = fl;
        e.name  = nm;
        e.stall = es;
        e.f0    = e0;
        e.f1    = e1;
        e.mask  = em;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; hsi_freeze = 1'b0; hsi_flush = 1'b0; hsi_issue_valid = 1'b0;
        hsi_wreg = 4'hf; hsi_wclass = 1'b0; hsi_src_addr = 8'hff;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        //    name        rs iv wr   wc s0   s1   frz fl  stall f0 f1 mask
        step("reset",     1, 0, 4'hf, 0, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0000);
        step("lu_issue",  1, 1, 4'h2, 1, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0000);
        step("lu_stall",  1, 0, 4'hf, 0, 4'h2, 4'hf, 0, 0, 1, 0, 0, 16'h0004);
        step("lu_age2",   1, 0, 4'hf, 0, 4'h2, 4'hf, 0, 0, 0, 2, 0, 16'h0004);
        step("lu_age3",   1, 0, 4'hf, 0, 4'h2, 4'hf, 0, 0, 0, 3, 0, 16'h0004);
        step("lu_retire", 1, 0, 4'hf, 0, 4'h2, 4'hf, 0, 0, 0, 0, 0, 16'h0000);
        step("alu_issue", 1, 1, 4'h3, 0, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0000);
        step("alu_age1",  1, 0, 4'hf, 0, 4'h3, 4'h3, 0, 0, 0, 1, 1, 16'h0008);
        step("alu_age2",  1, 0, 4'hf, 0, 4'h3, 4'h3, 0, 0, 0, 2, 2, 16'h0008);
        step("alu_age3",  1, 0, 4'hf, 0, 4'h3, 4'h3, 0, 0, 0, 3, 3, 16'h0008);
        step("alu_done",  1, 0, 4'hf, 0, 4'h3, 4'h3, 0, 0, 0, 0, 0, 16'h0000);
        step("yw_first",  1, 1, 4'h4, 0, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0000);
        step("yw_second", 1, 1, 4'h4, 0, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0010);
        step("yw_fwd1",   1, 0, 4'hf, 0, 4'h4, 4'hf, 0, 0, 0, 1, 0, 16'h0010);
        step("yw_load",   1, 1, 4'h4, 1, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0010);
        step("yw_alu",    1, 1, 4'h4, 0, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0010);
        step("yw_nostl",  1, 0, 4'hf, 0, 4'h4, 4'hf, 0, 0, 0, 1, 0, 16'h0010);
        step("fz_load",   1, 1, 4'h5, 1, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0010);
        step("fz_hold1",  1, 1, 4'h6, 0, 4'h5, 4'hf, 1, 0, 1, 0, 0, 16'h0030);
        step("fz_hold2",  1, 0, 4'hf, 0, 4'h5, 4'h4, 1, 0, 1, 0, 3, 16'h0030);
        step("fz_release",1, 0, 4'hf, 0, 4'h5, 4'h4, 0, 0, 1, 0, 3, 16'h0030);
        step("fz_age2",   1, 0, 4'hf, 0, 4'h5, 4'h6, 0, 0, 0, 2, 0, 16'h0020);
        step("fz_age3",   1, 0, 4'hf, 0, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0020);
        step("fl_r1",     1, 1, 4'h1, 0, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0000);
        step("fl_r6",     1, 1, 4'h6, 0, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0002);
        step("fl_pulse",  1, 1, 4'h7, 0, 4'h1, 4'h6, 0, 1, 0, 2, 1, 16'h0042);
        step("fl_empty",  1, 0, 4'hf, 0, 4'h7, 4'h1, 0, 0, 0, 0, 0, 16'h0000);
        step("inv_issue", 1, 1, 4'hf, 0, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0000);
        step("inv_after", 1, 0, 4'hf, 1, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0000);
        step("rs_load",   1, 1, 4'h2, 1, 4'hf, 4'hf, 0, 0, 0, 0, 0, 16'h0000);
        step("rs_stall",  1, 0, 4'hf, 0, 4'h2, 4'hf, 1, 0, 1, 0, 0, 16'h0004);
        step("rs_assert", 0, 0, 4'hf, 0, 4'h2, 4'hf, 1, 0, 0, 0, 0, 16'h0000);
        step("rs_release",1, 0, 4'hf, 0, 4'h2, 4'hf, 0, 0, 0, 0, 0, 16'h0000);
        step("rs_issue",  1, 1, 4'h3, 0, 4'h2, 4'hf, 0, 0, 0, 0, 0, 16'h0000);
        step("rs_fwd",    1, 0, 4'hf, 0, 4'h3, 4'hf, 0, 0, 0, 1, 0, 16'h0008);
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
